// File: rtl/ct_writeback_if.sv
// rtl/ct_writeback_if.sv - ciphertext stream and Wishbone read bus bundle for ct_writeback
interface ct_writeback_if #(
    parameter int ADDR_W = 5
);
    logic              ct_valid;
    logic [63:0]       ct_data;
    logic              ct_ready;
    logic              wb_stb;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_ack;
    logic [31:0]       wb_dat_o;

    modport master (
        output ct_valid, ct_data, wb_stb, wb_addr,
        input  ct_ready, wb_ack, wb_dat_o
    );

    modport slave (
        input  ct_valid, ct_data, wb_stb, wb_addr,
        output ct_ready, wb_ack, wb_dat_o
    );
endinterface

// File: rtl/ct_writeback.sv
// rtl/ct_writeback.sv - ASCON ciphertext writeback into SRAM with Wishbone readback (option: WB_STATUS_EN)
module ct_writeback #(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int BASE_ADDR = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        datalen,
    ct_writeback_if.slave     bus,
    output logic              mem_csb0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [31:0]       mem_din0,
    output logic              mem_csb1,
    output logic [ADDR_W-1:0] mem_addr1,
    input  logic [31:0]       mem_dout1,
    output logic              done,
    output logic              ovf_err
);
    localparam logic [7:0] LAST = 8'(DEPTH - 1);
    localparam logic [7:0] BASE = 8'(BASE_ADDR);

    typedef enum logic [2:0] {IDLE, RUN, W_HI, W_LO, DONE} state_t;

    state_t      state;
    logic [7:0]  left;
    logic [7:0]  ptr;
    logic [7:0]  ptr_nx;
    logic [31:0] blk_lo;

    // keep the first n bytes of a big-endian word, zero the rest
    function automatic logic [31:0] mask_word(input logic [31:0] w, input logic [7:0] n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (n > 8'(i)) m[31-8*i -: 8] = 8'hFF;
        end
        return w & m;
    endfunction

    assign ptr_nx = ptr + 8'd1;

    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            left         <= '0;
            ptr          <= '0;
            blk_lo       <= '0;
            bus.ct_ready <= 1'b0;
            mem_csb0     <= 1'b1;
            mem_addr0    <= '0;
            mem_din0     <= '0;
            done         <= 1'b0;
            ovf_err      <= 1'b0;
        end else if (start) begin
            left         <= datalen;
            ptr          <= BASE;
            ovf_err      <= 1'b0;
            mem_csb0     <= 1'b1;
            done         <= (datalen == 8'd0);
            bus.ct_ready <= (datalen != 8'd0);
            state        <= (datalen == 8'd0) ? DONE : RUN;
        end else begin
            case (state)
                IDLE: bus.ct_ready <= 1'b0;
                RUN: begin
                    if (bus.ct_valid) begin
                        blk_lo       <= bus.ct_data[31:0];
                        bus.ct_ready <= 1'b0;
                        mem_addr0    <= ptr[ADDR_W-1:0];
                        mem_din0     <= mask_word(bus.ct_data[63:32], left);
                        if (ptr > LAST) begin
                            mem_csb0 <= 1'b1;
                            ovf_err  <= 1'b1;
                        end else begin
                            mem_csb0 <= 1'b0;
                        end
                        state <= W_HI;
                    end
                end
                W_HI: begin
                    ptr <= ptr_nx;
                    if (left > 8'd4) begin
                        left      <= left - 8'd4;
                        mem_addr0 <= ptr_nx[ADDR_W-1:0];
                        mem_din0  <= mask_word(blk_lo, left - 8'd4);
                        if (ptr_nx > LAST) begin
                            mem_csb0 <= 1'b1;
                            ovf_err  <= 1'b1;
                        end else begin
                            mem_csb0 <= 1'b0;
                        end
                        state <= W_LO;
                    end else begin
                        left     <= '0;
                        mem_csb0 <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                W_LO: begin
                    ptr      <= ptr_nx;
                    mem_csb0 <= 1'b1;
                    if (left <= 8'd4) begin
                        left  <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        left         <= left - 8'd4;
                        bus.ct_ready <= 1'b1;
                        state        <= RUN;
                    end
                end
                DONE:    bus.ct_ready <= 1'b0;
                default: state <= IDLE;
            endcase
        end
    end

    // read select is driven straight from the strobe so the SRAM samples it on the first edge
    logic rd_pend;
    logic rd_issue;
    logic rd_stat;
    logic stat_sel;

`ifdef WB_STATUS_EN
    assign stat_sel = (bus.wb_addr == '1);
`else
    assign stat_sel = 1'b0;
`endif

    assign rd_issue  = !RST && bus.wb_stb && !bus.wb_ack && !rd_pend;
    assign mem_csb1  = !(rd_issue && !stat_sel);
    assign mem_addr1 = rd_issue ? bus.wb_addr : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            rd_pend      <= 1'b0;
            rd_stat      <= 1'b0;
            bus.wb_ack   <= 1'b0;
            bus.wb_dat_o <= '0;
        end else begin
            bus.wb_ack <= 1'b0;
            if (rd_issue) begin
                rd_pend <= 1'b1;
                rd_stat <= stat_sel;
            end
            if (rd_pend) begin
                rd_pend      <= 1'b0;
                bus.wb_ack   <= 1'b1;
                bus.wb_dat_o <= rd_stat ? {done, ovf_err, 22'b0, left} : mem_dout1;
            end
        end
    end
endmodule

// File: tb/tb_ct_writeback.sv
// tb/tb_ct_writeback.sv - directed self-checking bench for ct_writeback with a 32x32 SRAM model
module tb_ct_writeback;
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  datalen = '0;
    logic        mem_csb0, mem_csb1;
    logic [4:0]  mem_addr0, mem_addr1;
    logic [31:0] mem_din0;
    logic [31:0] mem_dout1;
    logic        done, ovf_err;
    logic [31:0] sram [32];
    int          vecs = 0;
    int          errs = 0;
    int          wr_cnt = 0;
    int          rdy_cnt = 0;

    ct_writeback_if #(.ADDR_W(5)) bus ();

    ct_writeback #(.ADDR_W(5), .DEPTH(32), .BASE_ADDR(16)) dut (
        .clk(clk), .RST(RST), .start(start), .datalen(datalen), .bus(bus),
        .mem_csb0(mem_csb0), .mem_addr0(mem_addr0), .mem_din0(mem_din0),
        .mem_csb1(mem_csb1), .mem_addr1(mem_addr1), .mem_dout1(mem_dout1),
        .done(done), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // SRAM model: reset fills a known pattern so untouched words are recognisable
    always @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) sram[i] <= 32'h5A000000 | i;
            mem_dout1 <= '0;
        end else begin
            if (!mem_csb0) begin
                sram[mem_addr0] <= mem_din0;
                wr_cnt <= wr_cnt + 1;
            end
            if (!mem_csb1) mem_dout1 <= sram[mem_addr1];
        end
        if (bus.ct_ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start = 1'b1;
        datalen = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] d);
        int n = 0;
        bus.ct_valid = 1'b1;
        bus.ct_data = d;
        while (!bus.ct_ready && n < 30) begin tick(); n++; end
        vecs++;
        if (!bus.ct_ready) begin errs++; $display("FAIL ready_timeout block=%h", d); end
        tick();
        bus.ct_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin tick(); n++; end
        vecs++;
        if (done !== 1'b1) begin errs++; $display("FAIL done_timeout got=%b want=1", done); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        vecs++;
        if ({bus.ct_ready, mem_csb0, mem_csb1, bus.wb_ack, done, ovf_err} !== 6'b011000) begin
            errs++;
            $display("FAIL reset_flags got=%b want=011000",
                     {bus.ct_ready, mem_csb0, mem_csb1, bus.wb_ack, done, ovf_err});
        end
        vecs++;
        if ({mem_addr0, mem_din0, mem_addr1, bus.wb_dat_o} !== '0) begin
            errs++;
            $display("FAIL reset_data got=%h want=0", {mem_addr0, mem_din0, mem_addr1, bus.wb_dat_o});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_full16();
        logic [31:0] exp [4];
        exp[0] = 32'h00112233; exp[1] = 32'h44556677; exp[2] = 32'h8899AABB; exp[3] = 32'hCCDDEEFF;
        do_start(8'd16);
        send_block(64'h0011223344556677);
        send_block(64'h8899AABBCCDDEEFF);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (sram[16+i] !== exp[i]) begin
                errs++; $display("FAIL full16_word%0d got=%h want=%h", 16 + i, sram[16+i], exp[i]);
            end
        end
        vecs++;
        if (bus.ct_ready !== 1'b0) begin errs++; $display("FAIL full16_ready got=%b want=0", bus.ct_ready); end
    endtask

    task automatic test_wb_read();
        logic [4:0]  addr [2];
        logic [31:0] exp  [2];
        logic        csb  [2];
        int n;
        addr[0] = 5'd17; exp[0] = 32'h44556677; csb[0] = 1'b0;
        addr[1] = 5'h1F;
`ifdef WB_STATUS_EN
        exp[1] = 32'h80000000; csb[1] = 1'b1;
`else
        exp[1] = 32'h5A00001F; csb[1] = 1'b0;
`endif
        for (int k = 0; k < 2; k++) begin
            bus.wb_stb = 1'b1;
            bus.wb_addr = addr[k];
            #1;
            vecs++;
            if (mem_csb1 !== csb[k]) begin errs++; $display("FAIL rd_csb1 addr=%h got=%b want=%b", addr[k], mem_csb1, csb[k]); end
            n = 0;
            while (!bus.wb_ack && n < 10) begin tick(); n++; end
            vecs++;
            if (n != 2) begin errs++; $display("FAIL rd_latency addr=%h got=%0d want=2", addr[k], n); end
            vecs++;
            if (bus.wb_dat_o !== exp[k]) begin errs++; $display("FAIL rd_data addr=%h got=%h want=%h", addr[k], bus.wb_dat_o, exp[k]); end
            vecs++;
            if (mem_csb1 !== 1'b1) begin errs++; $display("FAIL rd_reissue got=%b want=1", mem_csb1); end
            bus.wb_stb = 1'b0;
            tick();
            vecs++;
            if (bus.wb_ack !== 1'b0) begin errs++; $display("FAIL rd_ack_width got=%b want=0", bus.wb_ack); end
        end
    endtask

    task automatic test_partial6();
        do_start(8'd6);
        send_block(64'h0102030405060708);
        wait_done();
        vecs++;
        if (sram[16] !== 32'h01020304) begin errs++; $display("FAIL p6_word16 got=%h want=01020304", sram[16]); end
        vecs++;
        if (sram[17] !== 32'h05060000) begin errs++; $display("FAIL p6_word17 got=%h want=05060000", sram[17]); end
    endtask

    task automatic test_short3();
        int w0 = wr_cnt;
        do_start(8'd3);
        send_block(64'hAABBCCDD11223344);
        wait_done();
        tick();
        vecs++;
        if (sram[16] !== 32'hAABBCC00) begin errs++; $display("FAIL s3_word16 got=%h want=AABBCC00", sram[16]); end
        vecs++;
        if (wr_cnt - w0 != 1) begin errs++; $display("FAIL s3_writes got=%0d want=1", wr_cnt - w0); end
        vecs++;
        if (sram[17] !== 32'h05060000) begin errs++; $display("FAIL s3_word17 got=%h want=05060000", sram[17]); end
        vecs++;
        if (bus.ct_ready !== 1'b0) begin errs++; $display("FAIL s3_ready got=%b want=0", bus.ct_ready); end
    endtask

    task automatic test_zero();
        int w0 = wr_cnt;
        int r0 = rdy_cnt;
        do_start(8'd0);
        vecs++;
        if (done !== 1'b1) begin errs++; $display("FAIL z_done got=%b want=1", done); end
        for (int i = 0; i < 5; i++) tick();
        vecs++;
        if (wr_cnt != w0) begin errs++; $display("FAIL z_writes got=%0d want=0", wr_cnt - w0); end
        vecs++;
        if (rdy_cnt != r0) begin errs++; $display("FAIL z_ready_cycles got=%0d want=0", rdy_cnt - r0); end
    endtask

    task automatic test_restart();
        int w0 = wr_cnt;
        do_start(8'd8);
        bus.ct_valid = 1'b1;
        bus.ct_data = 64'hFFFFFFFFFFFFFFFF;
        start = 1'b1;
        datalen = 8'd4;
        tick();
        start = 1'b0;
        bus.ct_valid = 1'b0;
        vecs++;
        if ({bus.ct_ready, mem_csb0} !== 2'b11) begin
            errs++; $display("FAIL rs_state got=%b want=11", {bus.ct_ready, mem_csb0});
        end
        send_block(64'hDEADBEEF01234567);
        wait_done();
        tick();
        vecs++;
        if (sram[16] !== 32'hDEADBEEF) begin errs++; $display("FAIL rs_word16 got=%h want=DEADBEEF", sram[16]); end
        vecs++;
        if (wr_cnt - w0 != 1) begin errs++; $display("FAIL rs_writes got=%0d want=1", wr_cnt - w0); end
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt;
        do_start(8'd255);
        for (int k = 0; k < 32; k++) begin
            if (k == 8) begin
                tick(); tick();
                vecs++;
                if (ovf_err !== 1'b0) begin errs++; $display("FAIL ovf_early got=%b want=0", ovf_err); end
            end
            send_block({24'hA0B0C0, 8'(k), 24'hD0E0F0, 8'(k)});
        end
        wait_done();
        tick();
        vecs++;
        if (ovf_err !== 1'b1) begin errs++; $display("FAIL ovf_flag got=%b want=1", ovf_err); end
        vecs++;
        if (wr_cnt - w0 != 16) begin errs++; $display("FAIL ovf_writes got=%0d want=16", wr_cnt - w0); end
        vecs++;
        if (sram[16] !== 32'hA0B0C000) begin errs++; $display("FAIL ovf_word16 got=%h want=A0B0C000", sram[16]); end
        vecs++;
        if (sram[31] !== 32'hD0E0F007) begin errs++; $display("FAIL ovf_word31 got=%h want=D0E0F007", sram[31]); end
        vecs++;
        if (sram[0] !== 32'h5A000000) begin errs++; $display("FAIL ovf_word0 got=%h want=5A000000", sram[0]); end
    endtask

    task automatic test_rst_mid();
        do_start(8'd16);
        send_block(64'h1122334455667788);
        vecs++;
        if (mem_csb0 !== 1'b0) begin errs++; $display("FAIL rm_writing got=%b want=0", mem_csb0); end
        RST = 1'b1;
        tick();
        vecs++;
        if ({bus.ct_ready, mem_csb0, done, ovf_err, mem_addr0, mem_din0} !== {4'b0100, 37'b0}) begin
            errs++; $display("FAIL rm_outputs got=%h want=%h",
                             {bus.ct_ready, mem_csb0, done, ovf_err, mem_addr0, mem_din0}, {4'b0100, 37'b0});
        end
        RST = 1'b0;
        tick(); tick();
        vecs++;
        if ({bus.ct_ready, done} !== 2'b00) begin errs++; $display("FAIL rm_idle got=%b want=00", {bus.ct_ready, done}); end
    endtask

    initial begin
        bus.ct_valid = 1'b0;
        bus.ct_data = '0;
        bus.wb_stb = 1'b0;
        bus.wb_addr = '0;
        test_reset();
        test_full16();
        test_wb_read();
        test_partial6();
        test_short3();
        test_zero();
        test_restart();
        test_overflow();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
